// File: rtl/alt_frame_sequencer.sv
// Frame-level controller for the ambient-light/threshold statistics path:
// gates/clears accumulators, snapshots totals at frame end, and publishes four means via one serial divider.
module alt_frame_sequencer #(
  parameter int unsigned H_ACT     = 640,
  parameter int unsigned V_ACT     = 480,
  parameter int unsigned FRAME_PIX = 307200
) (
  input  logic        clk_25,
  input  logic        reset,
  input  logic        en_i,
  input  logic [9:0]  syncX_i,
  input  logic [9:0]  syncY_i,
  input  logic [31:0] tot_R_i,
  input  logic [31:0] tot_G_i,
  input  logic [31:0] tot_B_i,
  input  logic [31:0] tot_FD_i,
  output logic        acc_en_o,
  output logic        acc_clr_o,
  output logic [7:0]  AMB_SHIFT_R_o,
  output logic [7:0]  AMB_SHIFT_G_o,
  output logic [7:0]  AMB_SHIFT_B_o,
  output logic [31:0] thershold_o,
  output logic        stats_valid_o,
  output logic        busy_o,
  output logic        ovf_o
);

  localparam logic [9:0]  H_LAST  = 10'(H_ACT - 1);
  localparam logic [9:0]  V_LAST  = 10'(V_ACT - 1);
  localparam logic [31:0] DIVISOR = 32'(FRAME_PIX);

  typedef enum logic [2:0] {IDLE, ACCUM, LATCH, DIV, DONE} state_t;

  state_t      state, state_n;
  logic [31:0] d_r, d_g, d_b, d_f;
  logic [1:0]  ch;
  logic [5:0]  cnt;
  logic [31:0] quo, rem;
  logic [7:0]  q_r, q_g, q_b;
  logic [31:0] q_f;

  logic        active, fstart, fend;
  logic [31:0] dividend;
  logic [32:0] trial, diff;
  logic        ge;
  logic [31:0] rem_n, quo_n;
  logic [7:0]  sat8;

  assign active = (syncX_i <= H_LAST) && (syncY_i <= V_LAST);
  assign fstart = (syncX_i == '0) && (syncY_i == '0);
  assign fend   = (syncX_i == H_LAST) && (syncY_i == V_LAST);

  always_comb begin
    dividend = d_r;
    case (ch)
      2'd0: dividend = d_r;
      2'd1: dividend = d_g;
      2'd2: dividend = d_b;
      2'd3: dividend = d_f;
      default: dividend = d_r;
    endcase
  end

  // One restoring step: shift the next dividend bit into the remainder, subtract if it fits.
  always_comb begin
    trial = {rem, quo[31]};
    ge    = trial >= {1'b0, DIVISOR};
    diff  = trial - {1'b0, DIVISOR};
    rem_n = ge ? diff[31:0] : trial[31:0];
    quo_n = {quo[30:0], ge};
    sat8  = (|quo_n[31:8]) ? 8'hFF : quo_n[7:0];
  end

  always_comb begin
    state_n       = state;
    acc_en_o      = 1'b0;
    acc_clr_o     = 1'b0;
    stats_valid_o = 1'b0;
    busy_o        = 1'b0;
    case (state)
      IDLE: begin
        acc_clr_o = 1'b1;
        if (fstart && en_i) state_n = ACCUM;
      end
      ACCUM: begin
        acc_en_o = active;
        if (fend) state_n = LATCH;
      end
      LATCH: begin
        acc_clr_o = 1'b1;
        busy_o    = 1'b1;
        state_n   = DIV;
      end
      DIV: begin
        acc_en_o = active;
        busy_o   = 1'b1;
        if (cnt == 6'd32 && ch == 2'd3) state_n = DONE;
      end
      DONE: begin
        acc_en_o      = active;
        stats_valid_o = 1'b1;
        state_n       = en_i ? ACCUM : IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk_25) begin
    if (!reset) begin
      state         <= IDLE;
      d_r           <= '0;
      d_g           <= '0;
      d_b           <= '0;
      d_f           <= '0;
      ch            <= '0;
      cnt           <= '0;
      quo           <= '0;
      rem           <= '0;
      q_r           <= '0;
      q_g           <= '0;
      q_b           <= '0;
      q_f           <= '0;
      AMB_SHIFT_R_o <= '0;
      AMB_SHIFT_G_o <= '0;
      AMB_SHIFT_B_o <= '0;
      thershold_o   <= '0;
      ovf_o         <= 1'b0;
    end else begin
      state <= state_n;
      if (state == LATCH) begin
        d_r <= tot_R_i << 2;
        d_g <= tot_G_i << 2;
        d_b <= tot_B_i << 2;
        d_f <= tot_FD_i;
        ch  <= '0;
        cnt <= '0;
      end
      if (state == DIV) begin
        if (cnt == '0) begin
          quo <= dividend;
          rem <= '0;
          cnt <= 6'd1;
        end else begin
          quo <= quo_n;
          rem <= rem_n;
          if (cnt == 6'd32) begin
            cnt <= '0;
            ch  <= ch + 2'd1;
            case (ch)
              2'd0: q_r <= sat8;
              2'd1: q_g <= sat8;
              2'd2: q_b <= sat8;
              2'd3: q_f <= quo_n;
              default: q_r <= sat8;
            endcase
          end else begin
            cnt <= cnt + 6'd1;
          end
        end
      end
      if (state == DONE) begin
        AMB_SHIFT_R_o <= q_r;
        AMB_SHIFT_G_o <= q_g;
        AMB_SHIFT_B_o <= q_b;
        thershold_o   <= q_f;
      end
      // A frame end that arrives while the divider is still working is dropped.
      if (fend && (state == LATCH || state == DIV)) ovf_o <= 1'b1;
    end
  end

endmodule

// File: tb/tb_alt_frame_sequencer.sv
// Scoreboard bench for alt_frame_sequencer: stimulus queues expected publishes,
// a negedge monitor pops and compares on each stats_valid_o pulse.
module tb_alt_frame_sequencer;

  logic        clk_25 = 1'b0;
  logic        reset;
  logic        en_i;
  logic [9:0]  syncX_i, syncY_i;
  logic [31:0] tot_R_i, tot_G_i, tot_B_i, tot_FD_i;
  logic        acc_en_o, acc_clr_o, stats_valid_o, busy_o, ovf_o;
  logic [7:0]  AMB_SHIFT_R_o, AMB_SHIFT_G_o, AMB_SHIFT_B_o;
  logic [31:0] thershold_o;

  alt_frame_sequencer #(.H_ACT(640), .V_ACT(480), .FRAME_PIX(307200)) dut (
    .clk_25(clk_25), .reset(reset), .en_i(en_i),
    .syncX_i(syncX_i), .syncY_i(syncY_i),
    .tot_R_i(tot_R_i), .tot_G_i(tot_G_i), .tot_B_i(tot_B_i), .tot_FD_i(tot_FD_i),
    .acc_en_o(acc_en_o), .acc_clr_o(acc_clr_o),
    .AMB_SHIFT_R_o(AMB_SHIFT_R_o), .AMB_SHIFT_G_o(AMB_SHIFT_G_o), .AMB_SHIFT_B_o(AMB_SHIFT_B_o),
    .thershold_o(thershold_o), .stats_valid_o(stats_valid_o), .busy_o(busy_o), .ovf_o(ovf_o)
  );

  always #5 clk_25 = ~clk_25;

  typedef struct {
    logic [7:0]  r, g, b;
    logic [31:0] thr;
    int unsigned at;
  } exp_t;

  exp_t        sb[$];
  int          checks = 0;
  int          errors = 0;
  int unsigned cyc = 0;

  always @(posedge clk_25) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Monitor: strobe timing checked on the pulse, published values one cycle later.
  initial begin
    exp_t cur;
    bit   pend;
    pend = 1'b0;
    forever begin
      @(negedge clk_25);
      if (pend) begin
        check("amb_r", {24'd0, AMB_SHIFT_R_o}, {24'd0, cur.r});
        check("amb_g", {24'd0, AMB_SHIFT_G_o}, {24'd0, cur.g});
        check("amb_b", {24'd0, AMB_SHIFT_B_o}, {24'd0, cur.b});
        check("thr",   thershold_o, cur.thr);
        pend = 1'b0;
      end
      if (stats_valid_o === 1'b1) begin
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_valid: got 1 expected 0 (cycle %0d)", cyc);
        end else begin
          cur = sb.pop_front();
          check("valid_cycle", cyc, cur.at);
          pend = 1'b1;
        end
      end
    end
  end

  task automatic step(input logic [9:0] x, input logic [9:0] y);
    @(posedge clk_25);
    #1;
    syncX_i = x;
    syncY_i = y;
    #2;
  endtask

  task automatic push(input logic [7:0] r, input logic [7:0] g, input logic [7:0] b,
                      input logic [31:0] thr, input int unsigned fend_cyc);
    exp_t e;
    e.r = r; e.g = g; e.b = b; e.thr = thr; e.at = fend_cyc + 134;
    sb.push_back(e);
  endtask

  task automatic run_frame(input logic [31:0] tr, input logic [31:0] tg, input logic [31:0] tb_v,
                           input logic [31:0] tf, input logic [7:0] er, input logic [7:0] eg,
                           input logic [7:0] eb, input logic [31:0] ethr);
    tot_R_i = tr; tot_G_i = tg; tot_B_i = tb_v; tot_FD_i = tf;
    step(10'd0, 10'd0);
    step(10'd1, 10'd0);
    step(10'd639, 10'd479);
    push(er, eg, eb, ethr, cyc);
    repeat (140) step(10'd650, 10'd490);
  endtask

  initial begin
    int unsigned t;
    reset = 1'b0; en_i = 1'b0;
    syncX_i = 10'd700; syncY_i = 10'd500;
    tot_R_i = '0; tot_G_i = '0; tot_B_i = '0; tot_FD_i = '0;
    repeat (3) step(10'd700, 10'd500);
    check("rst_acc_clr", {31'd0, acc_clr_o}, 32'd1);
    check("rst_acc_en",  {31'd0, acc_en_o}, 32'd0);
    check("rst_busy",    {31'd0, busy_o}, 32'd0);
    check("rst_ovf",     {31'd0, ovf_o}, 32'd0);
    check("rst_valid",   {31'd0, stats_valid_o}, 32'd0);
    check("rst_amb_r",   {24'd0, AMB_SHIFT_R_o}, 32'd0);
    check("rst_thr",     thershold_o, 32'd0);
    reset = 1'b1;

    // Mid-frame start: nothing is gathered until the next (0,0).
    en_i = 1'b1;
    tot_R_i = 32'd153600;
    step(10'd320, 10'd200);
    step(10'd321, 10'd200);
    check("partial_acc_en",  {31'd0, acc_en_o}, 32'd0);
    check("partial_acc_clr", {31'd0, acc_clr_o}, 32'd1);
    step(10'd639, 10'd479);
    step(10'd650, 10'd490);
    check("partial_busy", {31'd0, busy_o}, 32'd0);
    repeat (140) step(10'd650, 10'd490);

    // First measured frame with blanking and DIV-time accumulation checks.
    step(10'd0, 10'd0);
    check("fstart_idle_acc_en", {31'd0, acc_en_o}, 32'd0);
    step(10'd1, 10'd0);
    check("accum_acc_en",  {31'd0, acc_en_o}, 32'd1);
    check("accum_acc_clr", {31'd0, acc_clr_o}, 32'd0);
    step(10'd700, 10'd5);
    check("blank_acc_en", {31'd0, acc_en_o}, 32'd0);
    step(10'd639, 10'd479);
    check("fend_acc_en", {31'd0, acc_en_o}, 32'd1);
    t = cyc;
    push(8'd2, 8'd0, 8'd0, 32'd0, t);
    step(10'd650, 10'd490);
    check("latch_busy",    {31'd0, busy_o}, 32'd1);
    check("latch_acc_clr", {31'd0, acc_clr_o}, 32'd1);
    step(10'd650, 10'd490);
    check("div_acc_clr", {31'd0, acc_clr_o}, 32'd0);
    check("div_blank_en", {31'd0, acc_en_o}, 32'd0);
    step(10'd5, 10'd5);
    check("div_active_en", {31'd0, acc_en_o}, 32'd1);
    repeat (140) step(10'd650, 10'd490);
    check("post_busy", {31'd0, busy_o}, 32'd0);
    check("hold_amb_r", {24'd0, AMB_SHIFT_R_o}, 32'd2);

    run_frame(32'd0, 32'd0, 32'd76800, 32'd3072000, 8'd0, 8'd0, 8'd1, 32'd10);
    run_frame(32'd20000000, 32'd0, 32'd0, 32'd0, 8'd255, 8'd0, 8'd0, 32'd0);
    run_frame(32'd19584000, 32'd0, 32'd0, 32'd0, 8'd255, 8'd0, 8'd0, 32'd0);
    run_frame(32'd19583999, 32'd153600, 32'd0, 32'd307199, 8'd254, 8'd2, 8'd0, 32'd0);

    // Overrun: second frame end in DIV with changed totals must not disturb the result.
    tot_R_i = 32'd460800; tot_G_i = '0; tot_B_i = '0; tot_FD_i = 32'd2150400;
    step(10'd0, 10'd0);
    step(10'd639, 10'd479);
    t = cyc;
    push(8'd6, 8'd0, 8'd0, 32'd7, t);
    check("pre_ovf", {31'd0, ovf_o}, 32'd0);
    repeat (49) step(10'd650, 10'd490);
    tot_R_i = '0; tot_FD_i = '0;
    step(10'd639, 10'd479);
    step(10'd650, 10'd490);
    check("ovf_set",  {31'd0, ovf_o}, 32'd1);
    check("ovf_busy", {31'd0, busy_o}, 32'd1);
    repeat (100) step(10'd650, 10'd490);
    check("ovf_sticky", {31'd0, ovf_o}, 32'd1);

    // en_i dropped mid-frame: frame still publishes, then back to IDLE.
    tot_R_i = '0; tot_G_i = 32'd307200; tot_B_i = '0; tot_FD_i = '0;
    step(10'd0, 10'd0);
    en_i = 1'b0;
    step(10'd1, 10'd0);
    step(10'd639, 10'd479);
    push(8'd0, 8'd4, 8'd0, 32'd0, cyc);
    repeat (140) step(10'd650, 10'd490);
    check("endrop_idle_clr", {31'd0, acc_clr_o}, 32'd1);

    // Reset during DIV: nothing published, outputs cleared.
    en_i = 1'b1;
    tot_R_i = 32'd153600; tot_G_i = '0;
    step(10'd0, 10'd0);
    step(10'd1, 10'd0);
    step(10'd639, 10'd479);
    repeat (59) step(10'd650, 10'd490);
    check("pre_rst_busy", {31'd0, busy_o}, 32'd1);
    @(posedge clk_25); #1; reset = 1'b0;
    @(posedge clk_25); #1; reset = 1'b1; #2;
    check("midrst_amb_g",   {24'd0, AMB_SHIFT_G_o}, 32'd0);
    check("midrst_ovf",     {31'd0, ovf_o}, 32'd0);
    check("midrst_acc_clr", {31'd0, acc_clr_o}, 32'd1);
    check("midrst_busy",    {31'd0, busy_o}, 32'd0);
    repeat (5) step(10'd650, 10'd490);
    step(10'd639, 10'd479);
    step(10'd650, 10'd490);
    check("no_fstart_busy", {31'd0, busy_o}, 32'd0);
    repeat (200) step(10'd650, 10'd490);

    check("sb_drained", sb.size(), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
